// File: rtl/uart_ctrl_param_pkg.sv
// Shared types for the UART configuration controller: line configuration,
// sticky error flags, the controller FSM states and the power-on configuration.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef struct packed {
        logic [15:0] baud_div;
        parity_e     parity;
        logic        stop2;
        logic [3:0]  data_bits;
    } uart_config_s;

    typedef struct packed {
        logic configuration;
        logic overrun;
        logic parity;
        logic frame;
    } uart_error_s;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_SEND,
        ST_ACK_WAIT,
        ST_APPLY,
        ST_SLV_ACK
    } uart_state_e;

    localparam uart_config_s STD_CONFIG = '{
        baud_div:  16'd434,
        parity:    PAR_NONE,
        stop2:     1'b0,
        data_bits: 4'd8
    };

    // Counter width; a one-value counter still needs one bit to exist.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_ctrl_param_if.sv
// Error/interrupt bundle between the controller and its sticky error latch.
interface uart_ctrl_param_if;
    import uart_pkg::*;

    logic        frame_err;
    logic        parity_err;
    logic        overrun_err;
    logic        int_ackn;
    logic        rx_empty;
    uart_error_s error;
    logic        irq;

    modport master (
        output frame_err, parity_err, overrun_err, int_ackn, rx_empty,
        input  error, irq
    );

    modport slave (
        input  frame_err, parity_err, overrun_err, int_ackn, rx_empty,
        output error, irq
    );

endinterface

// File: rtl/uart_ctrl_param_error_latch.sv
// Sticky error flags with host acknowledge, and the registered interrupt request.
module uart_error_latch
    import uart_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_err_i,
    uart_ctrl_param_if.slave  bus
);

    localparam int ERR_W = $bits(uart_error_s);

    logic [ERR_W-1:0] w_set;
    logic [ERR_W-1:0] w_err_next;
    logic [ERR_W-1:0] r_err;
    logic             r_irq;

    assign w_set = {cfg_err_i, bus.overrun_err, bus.parity_err, bus.frame_err};

    // A new error in the same cycle as an acknowledge must survive.
    generate
        for (genvar gi = 0; gi < ERR_W; gi++) begin : g_bit
            assign w_err_next[gi] = w_set[gi] | (r_err[gi] & ~bus.int_ackn);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= '0;
            r_irq <= 1'b0;
        end else begin
            r_err <= w_err_next;
            r_irq <= (|r_err) | ~bus.rx_empty;
        end
    end

    assign bus.error = uart_error_s'(r_err);
    assign bus.irq   = r_irq;

endmodule

// File: rtl/uart_ctrl_param.sv
// UART configuration handshake controller: master/slave configuration exchange
// with acknowledge timeout and retry, FIFO strobe gating and error reporting.
module uart_ctrl_param
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              config_req_mst_i,
    input  logic              std_config_i,
    input  uart_config_s      config_i,
    input  logic              config_req_slv_i,
    input  uart_config_s      rx_config_i,
    input  logic              req_ackn_i,
    input  logic              tx_done_i,
    input  logic              frame_error_i,
    input  logic              parity_error_i,
    input  logic              overrun_error_i,
    input  logic              rx_fifo_empty_i,
    input  logic              interrupt_ackn_i,
    input  logic [DATA_W-1:0] data_tx_i,
    input  logic              tx_fifo_write_i,
    input  logic              rx_fifo_read_i,
    output uart_config_s      config_o,
    output logic              config_req_mst_o,
    output logic              ack_tx_o,
    output logic              configuration_done_o,
    output logic              tx_fifo_write_o,
    output logic              rx_fifo_read_o,
    output logic [DATA_W-1:0] data_tx_o,
    output logic              cfg_busy_o,
    output uart_error_s       error_o,
    output logic              interrupt_o
);

    localparam int TO_W = cnt_w(TIMEOUT_CYC);
    localparam int RT_W = cnt_w(MAX_RETRY + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RT_W-1:0] RETRY_MAX = RT_W'(MAX_RETRY);

    uart_state_e     r_state;
    uart_state_e     w_state_next;
    logic [TO_W-1:0] r_to_cnt;
    logic [RT_W-1:0] r_retry;
    logic            r_mst_pend;
    logic            r_slv_pend;
    uart_config_s    r_rx_hold;
    uart_config_s    r_pend_cfg;
    uart_config_s    r_config;
    logic            r_req_mst;
    logic            r_ack_tx;
    logic            r_done;

    logic w_slv_any;
    logic w_mst_any;
    logic w_timeout;
    logic w_req_mst_next;
    logic w_ack_tx_next;
    logic w_done_next;
    logic w_cfg_err;
    logic w_retry_inc;
    logic w_load_mst;
    logic w_load_slv;

    assign w_slv_any = config_req_slv_i | r_slv_pend;
    assign w_mst_any = config_req_mst_i | r_mst_pend;
    assign w_timeout = (r_to_cnt == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_slv_any) begin
                    w_state_next = ST_SLV_ACK;
                end else if (w_mst_any) begin
                    w_state_next = ST_REQ_SEND;
                end
            end
            ST_REQ_SEND: begin
                if (tx_done_i) begin
                    w_state_next = ST_ACK_WAIT;
                end
            end
            ST_ACK_WAIT: begin
                if (req_ackn_i) begin
                    w_state_next = ST_APPLY;
                end else if (w_timeout) begin
                    w_state_next = (r_retry < RETRY_MAX) ? ST_REQ_SEND : ST_IDLE;
                end
            end
            ST_APPLY:   w_state_next = ST_IDLE;
            ST_SLV_ACK: begin
                if (tx_done_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Decisions taken on the transition; pulses are registered from these.
    always_comb begin
        w_req_mst_next = 1'b0;
        w_ack_tx_next  = 1'b0;
        w_done_next    = 1'b0;
        w_cfg_err      = 1'b0;
        w_retry_inc    = 1'b0;
        w_load_mst     = 1'b0;
        w_load_slv     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_slv_any) begin
                    w_ack_tx_next = 1'b1;
                    w_load_slv    = 1'b1;
                end else if (w_mst_any) begin
                    w_req_mst_next = 1'b1;
                    w_load_mst     = 1'b1;
                end
            end
            ST_ACK_WAIT: begin
                if (req_ackn_i) begin
                    w_done_next = 1'b1;
                end else if (w_timeout) begin
                    if (r_retry < RETRY_MAX) begin
                        w_req_mst_next = 1'b1;
                        w_retry_inc    = 1'b1;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            ST_SLV_ACK: begin
                if (tx_done_i) begin
                    w_done_next = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt   <= '0;
            r_retry    <= '0;
            r_mst_pend <= 1'b0;
            r_slv_pend <= 1'b0;
            r_rx_hold  <= STD_CONFIG;
            r_pend_cfg <= STD_CONFIG;
            r_config   <= STD_CONFIG;
            r_req_mst  <= 1'b0;
            r_ack_tx   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_req_mst <= w_req_mst_next;
            r_ack_tx  <= w_ack_tx_next;
            r_done    <= w_done_next;

            // One pending register serves both paths; only one exchange is in flight.
            if (w_load_slv) begin
                r_pend_cfg <= config_req_slv_i ? rx_config_i : r_rx_hold;
            end else if (w_load_mst) begin
                r_pend_cfg <= std_config_i ? STD_CONFIG : config_i;
            end

            if (w_done_next) begin
                r_config <= r_pend_cfg;
            end

            if (r_state == ST_ACK_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if (w_load_mst) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end

            if (w_load_mst) begin
                r_mst_pend <= 1'b0;
            end else if (config_req_mst_i) begin
                r_mst_pend <= 1'b1;
            end

            if (w_load_slv) begin
                r_slv_pend <= 1'b0;
            end else if (config_req_slv_i) begin
                r_slv_pend <= 1'b1;
                r_rx_hold  <= rx_config_i;
            end
        end
    end

    uart_ctrl_param_if u_err_if ();

    assign u_err_if.frame_err   = frame_error_i;
    assign u_err_if.parity_err  = parity_error_i;
    assign u_err_if.overrun_err = overrun_error_i;
    assign u_err_if.int_ackn    = interrupt_ackn_i;
    assign u_err_if.rx_empty    = rx_fifo_empty_i;

    uart_error_latch u_err_latch (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cfg_err_i (w_cfg_err),
        .bus       (u_err_if.slave)
    );

    assign error_o              = u_err_if.error;
    assign interrupt_o          = u_err_if.irq;
    assign config_o             = r_config;
    assign config_req_mst_o     = r_req_mst;
    assign ack_tx_o             = r_ack_tx;
    assign configuration_done_o = r_done;
    assign cfg_busy_o           = (r_state != ST_IDLE);
    assign tx_fifo_write_o      = tx_fifo_write_i & (r_state == ST_IDLE);
    assign data_tx_o            = data_tx_i;
    assign rx_fifo_read_o       = rx_fifo_read_i;

endmodule

// File: doc/uart_ctrl_param.md
UART_CTRL_PARAM -- requirements
Module: uart_ctrl_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 8, data width; legal 5..9.
- TIMEOUT_CYC, 1024, clk_i cycles to wait for a configuration acknowledge.
- MAX_RETRY, 3, configuration request retransmissions before abort.

REQ-002 The block SHALL use one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- config_req_mst_i, in, 1, host requests new configuration (1-cycle pulse).
- std_config_i, in, 1, use STD_CONFIG instead of config_i.
- config_i, in, uart_config_s, host configuration.
- config_req_slv_i, in, 1, remote configuration request received (pulse).
- rx_config_i, in, uart_config_s, configuration carried by the remote request.
- req_ackn_i, in, 1, remote acknowledge received (pulse).
- tx_done_i, in, 1, transmitter finished a frame (pulse).
- frame_error_i, parity_error_i, overrun_error_i, in, 1 each, error pulses.
- rx_fifo_empty_i, in, 1, RX FIFO empty.
- interrupt_ackn_i, in, 1, host interrupt acknowledge (pulse).
- data_tx_i, in, DATA_W, host TX data.
- tx_fifo_write_i, rx_fifo_read_i, in, 1 each, host FIFO strobes.
- config_o, out, uart_config_s, active configuration.
- config_req_mst_o, out, 1, send configuration request frame (pulse).
- ack_tx_o, out, 1, send acknowledge frame (pulse).
- configuration_done_o, out, 1, new configuration applied (pulse).
- tx_fifo_write_o, rx_fifo_read_o, out, 1 each, gated FIFO strobes.
- data_tx_o, out, DATA_W, TX data to FIFO.
- cfg_busy_o, out, 1, configuration in progress.
- error_o, out, uart_error_s, sticky error flags.
- interrupt_o, out, 1, interrupt request.

Function
REQ-004 The FSM SHALL have the states IDLE, REQ_SEND, ACK_WAIT, APPLY, and SLV_ACK; cfg_busy_o SHALL be 1 in every state except IDLE.

REQ-005 In IDLE, if a pending slave request exists, the FSM SHALL latch rx_config_i, pulse ack_tx_o, and go to SLV_ACK; a slave request SHALL win over a simultaneous master request.

REQ-006 In IDLE with no slave request, a pending master request SHALL latch (std_config_i ? STD_CONFIG : config_i) into pending_cfg, pulse config_req_mst_o, clear retry_cnt, and go to REQ_SEND.

REQ-007 A master request arriving outside IDLE or losing to a slave request SHALL be held in a 1-bit sticky flag and served on the next IDLE cycle; further requests while the flag is set SHALL be merged into it.

REQ-008 In REQ_SEND, tx_done_i SHALL move the FSM to ACK_WAIT with the timeout counter cleared to 0.

REQ-009 In ACK_WAIT, req_ackn_i SHALL move the FSM to APPLY; req_ackn_i on the same cycle as timeout SHALL take precedence over timeout.

REQ-010 In ACK_WAIT, when the counter reaches TIMEOUT_CYC-1 with retry_cnt < MAX_RETRY, the block SHALL increment retry_cnt, pulse config_req_mst_o, and go to REQ_SEND.

REQ-011 When the counter reaches TIMEOUT_CYC-1 with retry_cnt = MAX_RETRY, the block SHALL set error_o.configuration, leave config_o unchanged, and go to IDLE.

REQ-012 APPLY SHALL last one cycle, load config_o from pending_cfg, pulse configuration_done_o, and go to IDLE.

REQ-013 In SLV_ACK, tx_done_i SHALL load config_o from the latched rx_config_i, pulse configuration_done_o, and go to IDLE.

REQ-014 A config_req_slv_i arriving outside IDLE SHALL be held in a sticky flag, with the last rx_config_i value captured in that cycle.

REQ-015 The FIFO path SHALL behave as follows:
- tx_fifo_write_o = tx_fifo_write_i AND state==IDLE, combinational.
- data_tx_o = data_tx_i.
- rx_fifo_read_o = rx_fifo_read_i.
- Host writes made during configuration SHALL be dropped.

REQ-016 Error flags SHALL behave as follows:
- Each error_o bit is set on its input pulse and cleared by interrupt_ackn_i.
- A set and an acknowledge in the same cycle SHALL leave the bit set.

REQ-017 interrupt_o SHALL be registered, with 1-cycle latency, equal to (OR of the error_o bits) OR NOT rx_fifo_empty_i.

REQ-018 Only pulse outputs SHALL be single-cycle; none SHALL be asserted for two consecutive cycles.

Reset
REQ-019 Reset SHALL produce the following output values:
- State IDLE.
- config_o = STD_CONFIG.
- error_o = 0, interrupt_o = 0.
- All pulse outputs 0, cfg_busy_o = 0.
- Sticky request flags, counters, and retry_cnt all 0.

REQ-020 Reset asserted mid-configuration SHALL abort it with no configuration_done_o and config_o = STD_CONFIG.

Structure
REQ-021 uart_config_s, uart_error_s, STD_CONFIG, and the FSM state enum SHALL reside in UART_PKG.

REQ-022 The timeout and retry counters SHALL be sized $clog2(TIMEOUT_CYC) and $clog2(MAX_RETRY+1).

REQ-023 The sticky error/interrupt logic SHALL be a sub-module uart_error_latch; all other logic SHALL be flat.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Master request with std_config_i=0, tx_done_i at cycle 5, req_ackn_i at cycle 20 -> config_o = config_i and configuration_done_o at cycle 21.
- TIMEOUT_CYC=16, MAX_RETRY=3, no acknowledge -> 4 config_req_mst_o pulses, then error_o.configuration=1, config_o unchanged, cfg_busy_o=0.
- config_req_slv_i and config_req_mst_i in the same cycle -> ack_tx_o first; after tx_done_i, config_o = rx_config_i; the master request then starts on the next IDLE cycle.
- parity_error_i and interrupt_ackn_i in the same cycle -> parity bit stays 1 and interrupt_o=1; a later acknowledge clears both, provided rx_fifo_empty_i=1.
- tx_fifo_write_i held high during ACK_WAIT -> tx_fifo_write_o=0 throughout.
- rst_i in ACK_WAIT -> next cycle state IDLE, config_o = STD_CONFIG, no configuration_done_o.
- DATA_W=9 build: data_tx_o equals data_tx_i over the full 9-bit range.
